// File: rtl/simon_pkg.sv
// Shared definitions for the Simon 128/128 cores (encrypt and decrypt).
// Contents: word/round constants, the z2 key-schedule sequence, the key
// constant, the round function f and the forward/backward key-step
// functions, and the FSM state type used by the iterative cores.
package simon_pkg;

  localparam int WORD_W        = 64;
  localparam int ROUNDS        = 68;
  localparam int KEY_FWD_STEPS = 66;

  // z2 sequence; bit i of the vector is element i of the sequence.
  localparam logic [61:0] Z2    = 62'h3369_F885_192C_0EF5;
  localparam logic [63:0] C_KEY = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYFWD = 2'd1,
    ST_DEC    = 2'd2
  } state_e;

  // f(x) = (S1 x & S8 x) ^ S2 x, S = rotate left.
  function automatic word_t simon_f(input word_t x);
    word_t s1, s2, s8;
    s1 = {x[62:0], x[63]};
    s2 = {x[61:0], x[63:62]};
    s8 = {x[55:0], x[63:56]};
    return (s1 & s8) ^ s2;
  endfunction

  // t(k) = S^-3 k ^ S^-4 k (rotate right by 3 and by 4).
  function automatic word_t key_mix(input word_t k);
    return {k[2:0], k[63:3]} ^ {k[3:0], k[63:4]};
  endfunction

  // z2 element with the index reduced mod 62 (indices never exceed 123).
  function automatic logic z_bit(input logic [6:0] idx);
    logic [6:0] m;
    m = (idx >= 7'd62) ? idx - 7'd62 : idx;
    return Z2[m[5:0]];
  endfunction

  // k[i+2] from k[i] and k[i+1].
  function automatic word_t key_fwd(input word_t ki, input word_t ki1,
                                    input logic [6:0] idx);
    return C_KEY ^ {63'd0, z_bit(idx)} ^ ki ^ key_mix(ki1);
  endfunction

  // k[i] from k[i+2] and k[i+1].
  function automatic word_t key_bwd(input word_t ki2, input word_t ki1,
                                    input logic [6:0] idx);
    return ki2 ^ C_KEY ^ {63'd0, z_bit(idx)} ^ key_mix(ki1);
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// Combinational Simon 128/128 key-schedule step, shared by the forward
// key expansion and the backward schedule used during decryption.
// Ports:
//   dir_bwd : 0 = forward  (ka = k[i],   kb = k[i+1]) -> k_next = k[i+2]
//             1 = backward (ka = k[i+1], kb = k[i+2]) -> k_next = k[i]
//   ka, kb  : current key-pair register contents
//   idx     : z2 index i (reduced mod 62 inside)
//   k_next  : newly computed key word
module simon_key_step
  import simon_pkg::*;
(
  input  logic       dir_bwd,
  input  word_t      ka,
  input  word_t      kb,
  input  logic [6:0] idx,
  output word_t      k_next
);

  // The pair register holds (older, newer) going forward and
  // (newer-index-minus-one, newer) going backward, so the operand roles swap.
  always_comb begin
    if (dir_bwd) k_next = key_bwd(kb, ka, idx);
    else         k_next = key_fwd(ka, kb, idx);
  end

endmodule

// File: rtl/simon_decrypt.sv
// Simon 128/128 iterative decryption core, exact inverse of top_simon.
// Expands the key schedule forward for 66 cycles to reach (k66, k67), then
// runs 68 inverse rounds while stepping the schedule backwards.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start_i    : request, sampled only while idle
//   ct_i       : ciphertext, x = [127:64], y = [63:0]
//   k0_i       : master key, k[1] = [127:64], k[0] = [63:0]
//   busy_o     : operation in progress
//   valid_o    : one-cycle pulse when pt_o updates
//   pt_o       : plaintext, x = [127:64], y = [63:0], held until next result
module simon_decrypt
  import simon_pkg::*;
#(
  parameter int ROUNDS = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] ct_i,
  input  logic [127:0] k0_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] pt_o
);

  localparam logic [6:0] LAST_FWD   = 7'(KEY_FWD_STEPS - 1);
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  state_e     state;
  word_t      x_q, y_q;
  word_t      ka_q, kb_q;
  logic [6:0] cnt_q;      // z index in KEYFWD, round number r in DEC

  logic       dir_bwd;
  logic [6:0] key_idx;
  word_t      k_next;
  word_t      y_next;

  // Backward step for round r produces k[r-2]; for r < 2 the value is
  // unused, so the index is simply clamped to keep it in range.
  always_comb begin
    dir_bwd = (state == ST_DEC);
    key_idx = cnt_q;
    if (state == ST_DEC) key_idx = (cnt_q >= 7'd2) ? cnt_q - 7'd2 : 7'd0;
  end

  assign y_next = x_q ^ simon_f(y_q) ^ kb_q;

  simon_key_step u_key_step (
    .dir_bwd (dir_bwd),
    .ka      (ka_q),
    .kb      (kb_q),
    .idx     (key_idx),
    .k_next  (k_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      pt_o    <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            x_q    <= ct_i[127:64];
            y_q    <= ct_i[63:0];
            ka_q   <= k0_i[63:0];
            kb_q   <= k0_i[127:64];
            cnt_q  <= '0;
            busy_o <= 1'b1;
            state  <= ST_KEYFWD;
          end
        end
        // Forward expansion: after the last step the pair is (k66, k67).
        ST_KEYFWD: begin
          ka_q <= kb_q;
          kb_q <= k_next;
          if (cnt_q == LAST_FWD) begin
            cnt_q <= LAST_ROUND;
            state <= ST_DEC;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        // Inverse rounds: kb holds k[r], ka holds k[r-1].
        ST_DEC: begin
          x_q  <= y_q;
          y_q  <= y_next;
          ka_q <= k_next;
          kb_q <= ka_q;
          if (cnt_q == 7'd0) begin
            pt_o    <= {y_q, y_next};
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 7'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
